loop_gain_detector: RTL and testbench

LOOP_GAIN_DETECTOR -- requirements
Module: loop_gain_detector

---
 rtl/loop_gain_detector.sv | 167 ++++++++++++++++
 tb/tb_loop_gain_detector.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/loop_gain_detector.sv
// Synchronous I/Q correlator for loop-gain measurement. The injected tone is sampled at
// exactly 4x its frequency, so demodulation reduces to add/subtract on a 2-bit phase.
module loop_gain_detector #(
    parameter  int DW    = 12,
    parameter  int NPER  = 256,
    parameter  int NSKIP = 16,
    localparam int AW    = DW + $clog2(NPER) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 s_valid,
    input  logic signed [DW-1:0] s_in,
    input  logic signed [DW-1:0] s_out,
    output logic                 busy,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic signed [AW-1:0] i_in,
    output logic signed [AW-1:0] q_in,
    output logic signed [AW-1:0] i_out,
    output logic signed [AW-1:0] q_out
);

    localparam int CW = 11;
    localparam logic [CW-1:0] SKIP_LAST = CW'(NSKIP > 0 ? NSKIP - 1 : 0);
    localparam logic [CW-1:0] NPER_LAST = CW'(NPER - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, ACQ, HOLD} state_t;

    state_t               state_q, state_d;
    logic [1:0]           phase_q, phase_d;
    logic [CW-1:0]        per_q, per_d;
    logic                 busy_q, busy_d;
    logic                 res_valid_q, res_valid_d;
    logic signed [AW-1:0] acc_i_in_q, acc_i_in_d, acc_q_in_q, acc_q_in_d;
    logic signed [AW-1:0] acc_i_out_q, acc_i_out_d, acc_q_out_q, acc_q_out_d;
    logic signed [AW-1:0] res_i_in_q, res_i_in_d, res_q_in_q, res_q_in_d;
    logic signed [AW-1:0] res_i_out_q, res_i_out_d, res_q_out_q, res_q_out_d;
    logic signed [AW-1:0] x_in, x_out;

    assign x_in  = {{(AW-DW){s_in[DW-1]}}, s_in};
    assign x_out = {{(AW-DW){s_out[DW-1]}}, s_out};

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        per_d       = per_q;
        res_valid_d = res_valid_q;
        acc_i_in_d  = acc_i_in_q;
        acc_q_in_d  = acc_q_in_q;
        acc_i_out_d = acc_i_out_q;
        acc_q_out_d = acc_q_out_q;
        res_i_in_d  = res_i_in_q;
        res_q_in_d  = res_q_in_q;
        res_i_out_d = res_i_out_q;
        res_q_out_d = res_q_out_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    phase_d     = '0;
                    per_d       = '0;
                    acc_i_in_d  = '0;
                    acc_q_in_d  = '0;
                    acc_i_out_d = '0;
                    acc_q_out_d = '0;
                    state_d     = (NSKIP > 0) ? SETTLE : ACQ;
                end
            end
            SETTLE: begin
                if (s_valid) begin
                    phase_d = phase_q + 2'd1;
                    if (phase_q == 2'd3) begin
                        if (per_q == SKIP_LAST) begin
                            per_d   = '0;
                            state_d = ACQ;
                        end else begin
                            per_d = per_q + 1'b1;
                        end
                    end
                end
            end
            ACQ: begin
                if (s_valid) begin
                    // Quadrature reference at 4x sampling is the sequence +1, +j, -1, -j.
                    case (phase_q)
                        2'd0: begin
                            acc_i_in_d  = acc_i_in_q + x_in;
                            acc_i_out_d = acc_i_out_q + x_out;
                        end
                        2'd1: begin
                            acc_q_in_d  = acc_q_in_q + x_in;
                            acc_q_out_d = acc_q_out_q + x_out;
                        end
                        2'd2: begin
                            acc_i_in_d  = acc_i_in_q - x_in;
                            acc_i_out_d = acc_i_out_q - x_out;
                        end
                        default: begin
                            acc_q_in_d  = acc_q_in_q - x_in;
                            acc_q_out_d = acc_q_out_q - x_out;
                        end
                    endcase
                    phase_d = phase_q + 2'd1;
                    if (phase_q == 2'd3) begin
                        if (per_q == NPER_LAST) begin
                            res_i_in_d  = acc_i_in_d;
                            res_q_in_d  = acc_q_in_d;
                            res_i_out_d = acc_i_out_d;
                            res_q_out_d = acc_q_out_d;
                            res_valid_d = 1'b1;
                            state_d     = HOLD;
                        end else begin
                            per_d = per_q + 1'b1;
                        end
                    end
                end
            end
            default: begin
                if (res_valid_q && res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
        endcase
        busy_d = (state_d == SETTLE) || (state_d == ACQ);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            phase_q     <= '0;
            per_q       <= '0;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
            acc_i_in_q  <= '0;
            acc_q_in_q  <= '0;
            acc_i_out_q <= '0;
            acc_q_out_q <= '0;
            res_i_in_q  <= '0;
            res_q_in_q  <= '0;
            res_i_out_q <= '0;
            res_q_out_q <= '0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            per_q       <= per_d;
            busy_q      <= busy_d;
            res_valid_q <= res_valid_d;
            acc_i_in_q  <= acc_i_in_d;
            acc_q_in_q  <= acc_q_in_d;
            acc_i_out_q <= acc_i_out_d;
            acc_q_out_q <= acc_q_out_d;
            res_i_in_q  <= res_i_in_d;
            res_q_in_q  <= res_q_in_d;
            res_i_out_q <= res_i_out_d;
            res_q_out_q <= res_q_out_d;
        end
    end

    assign busy      = busy_q;
    assign res_valid = res_valid_q;
    assign i_in      = res_i_in_q;
    assign q_in      = res_q_in_q;
    assign i_out     = res_i_out_q;
    assign q_out     = res_q_out_q;

endmodule

// File: tb/tb_loop_gain_detector.sv
// Directed bench for loop_gain_detector: three instances cover NPER=4/NSKIP=0,
// NPER=4/NSKIP=2 and the default parameter set.
module tb_loop_gain_detector;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: NPER=4, NSKIP=0
    logic               rst_n_a, start_a, s_valid_a, res_ready_a, busy_a, res_valid_a;
    logic signed [11:0] s_in_a, s_out_a;
    logic signed [14:0] i_in_a, q_in_a, i_out_a, q_out_a;

    // Instances B (NPER=4, NSKIP=2) and C (defaults) share their inputs
    logic               rst_n_bc, start_bc, s_valid_bc, res_ready_bc;
    logic signed [11:0] s_in_bc, s_out_bc;
    logic               busy_b, res_valid_b, busy_c, res_valid_c;
    logic signed [14:0] i_in_b, q_in_b, i_out_b, q_out_b;
    logic signed [20:0] i_in_c, q_in_c, i_out_c, q_out_c;

    loop_gain_detector #(.DW(12), .NPER(4), .NSKIP(0)) dut_a (
        .clk(clk), .rst_n(rst_n_a), .start(start_a), .s_valid(s_valid_a),
        .s_in(s_in_a), .s_out(s_out_a), .busy(busy_a), .res_valid(res_valid_a),
        .res_ready(res_ready_a), .i_in(i_in_a), .q_in(q_in_a), .i_out(i_out_a), .q_out(q_out_a)
    );

    loop_gain_detector #(.DW(12), .NPER(4), .NSKIP(2)) dut_b (
        .clk(clk), .rst_n(rst_n_bc), .start(start_bc), .s_valid(s_valid_bc),
        .s_in(s_in_bc), .s_out(s_out_bc), .busy(busy_b), .res_valid(res_valid_b),
        .res_ready(res_ready_bc), .i_in(i_in_b), .q_in(q_in_b), .i_out(i_out_b), .q_out(q_out_b)
    );

    loop_gain_detector dut_c (
        .clk(clk), .rst_n(rst_n_bc), .start(start_bc), .s_valid(s_valid_bc),
        .s_in(s_in_bc), .s_out(s_out_bc), .busy(busy_c), .res_valid(res_valid_c),
        .res_ready(res_ready_bc), .i_in(i_in_c), .q_in(q_in_c), .i_out(i_out_c), .q_out(q_out_c)
    );

    typedef struct packed {
        logic signed [11:0] si0, si1, si2, si3;
        logic signed [11:0] so0, so1, so2, so3;
        int                 ei_in, eq_in, ei_out, eq_out;
    } vec_t;

    vec_t vecs [4];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic signed [11:0] pin(input vec_t v, input int k);
        case (k % 4)
            0:       return v.si0;
            1:       return v.si1;
            2:       return v.si2;
            default: return v.si3;
        endcase
    endfunction

    function automatic logic signed [11:0] pout(input vec_t v, input int k);
        case (k % 4)
            0:       return v.so0;
            1:       return v.so1;
            2:       return v.so2;
            default: return v.so3;
        endcase
    endfunction

    task automatic chk_res_a(input string tag, input vec_t v);
        chk({tag, "_i_in"},  i_in_a,  v.ei_in);
        chk({tag, "_q_in"},  q_in_a,  v.eq_in);
        chk({tag, "_i_out"}, i_out_a, v.ei_out);
        chk({tag, "_q_out"}, q_out_a, v.eq_out);
    endtask

    // One full NPER=4 measurement on instance A (16 samples), optionally with idle gaps
    task automatic run_a(input string tag, input vec_t v, input bit gaps, input bit release_it);
        int g;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        chk({tag, "_busy"}, busy_a, 1);
        for (int k = 0; k < 16; k++) begin
            if (gaps) begin
                g = $urandom_range(0, 2);
                repeat (g) begin
                    s_valid_a = 1'b0;
                    s_in_a    = 12'sd555;
                    s_out_a   = -12'sd555;
                    step();
                end
            end
            s_valid_a = 1'b1;
            s_in_a    = pin(v, k);
            s_out_a   = pout(v, k);
            step();
            if (k == 14) chk({tag, "_rv_early"}, res_valid_a, 0);
        end
        s_valid_a = 1'b0;
        chk({tag, "_rv"}, res_valid_a, 1);
        chk({tag, "_busy_done"}, busy_a, 0);
        chk_res_a(tag, v);
        if (release_it) begin
            res_ready_a = 1'b1;
            step();
            res_ready_a = 1'b0;
            chk({tag, "_rv_clr"}, res_valid_a, 0);
        end
    endtask

    initial begin
        vecs[0] = '{12'sd100, 12'sd0, -12'sd100, 12'sd0,
                    12'sd7, 12'sd7, 12'sd7, 12'sd7, 800, 0, 0, 0};
        vecs[1] = '{12'sd0, 12'sd50, 12'sd0, -12'sd50,
                    12'sd10, 12'sd20, 12'sd30, 12'sd40, 0, 400, -80, -80};
        vecs[2] = '{-12'sd2048, -12'sd2048, 12'sd2047, 12'sd2047,
                    12'sd2047, -12'sd2048, -12'sd2048, 12'sd2047, -16380, -16380, 16380, -16380};
        vecs[3] = '{12'sd1, 12'sd2, 12'sd3, 12'sd4,
                    -12'sd5, 12'sd0, 12'sd5, 12'sd0, -8, -8, -40, 0};

        rst_n_a = 1'b0; start_a = 1'b0; s_valid_a = 1'b0; res_ready_a = 1'b0;
        s_in_a = '0; s_out_a = '0;
        rst_n_bc = 1'b0; start_bc = 1'b0; s_valid_bc = 1'b0; res_ready_bc = 1'b0;
        s_in_bc = '0; s_out_bc = '0;
        step();
        step();
        chk("rst_busy_a", busy_a, 0);
        chk("rst_rv_a", res_valid_a, 0);
        chk("rst_i_in_a", i_in_a, 0);
        chk("rst_busy_b", busy_b, 0);
        rst_n_a  = 1'b1;
        rst_n_bc = 1'b1;
        step();

        for (int i = 0; i < 4; i++) run_a($sformatf("vec%0d", i), vecs[i], 1'b0, 1'b1);

        run_a("gaps", vecs[0], 1'b1, 1'b1);

        // Result held under backpressure while start and s_valid toggle
        run_a("hold", vecs[1], 1'b0, 1'b0);
        for (int c = 0; c < 20; c++) begin
            start_a   = (c % 5 == 0);
            s_valid_a = (c % 2 == 1);
            s_in_a    = 12'($urandom_range(0, 4095));
            s_out_a   = 12'($urandom_range(0, 4095));
            step();
        end
        start_a = 1'b0; s_valid_a = 1'b0;
        chk("hold_rv", res_valid_a, 1);
        chk("hold_busy", busy_a, 0);
        chk_res_a("hold_after", vecs[1]);
        res_ready_a = 1'b1;
        step();
        res_ready_a = 1'b0;
        chk("hold_rel_rv", res_valid_a, 0);
        chk("hold_rel_busy", busy_a, 0);
        s_valid_a = 1'b1;
        step();
        s_valid_a = 1'b0;
        chk("idle_busy", busy_a, 0);
        chk("idle_q_in", q_in_a, 400);

        // Reset mid-acquisition, with start asserted on the reset edge
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        for (int k = 0; k < 6; k++) begin
            s_valid_a = 1'b1; s_in_a = pin(vecs[0], k); s_out_a = pout(vecs[0], k);
            step();
        end
        s_valid_a = 1'b0;
        rst_n_a = 1'b0;
        start_a = 1'b1;
        step();
        rst_n_a = 1'b1;
        start_a = 1'b0;
        chk("mrst_busy", busy_a, 0);
        chk("mrst_rv", res_valid_a, 0);
        chk_res_a("mrst", '{12'sd0, 12'sd0, 12'sd0, 12'sd0, 12'sd0, 12'sd0, 12'sd0, 12'sd0, 0, 0, 0, 0});
        step();
        chk("mrst_busy2", busy_a, 0);
        run_a("after_rst", vecs[0], 1'b0, 1'b1);

        // Instance B: 8 settle samples of 999 must not contribute
        start_bc = 1'b1;
        step();
        start_bc = 1'b0;
        chk("b_busy", busy_b, 1);
        for (int k = 0; k < 8; k++) begin
            s_valid_bc = 1'b1; s_in_bc = 12'sd999; s_out_bc = 12'sd999;
            step();
        end
        for (int k = 0; k < 16; k++) begin
            s_valid_bc = 1'b1;
            case (k % 4)
                0:       begin s_in_bc = 12'sd30;  s_out_bc = 12'sd0;   end
                1:       begin s_in_bc = 12'sd0;   s_out_bc = 12'sd50;  end
                2:       begin s_in_bc = -12'sd30; s_out_bc = 12'sd0;   end
                default: begin s_in_bc = 12'sd0;   s_out_bc = -12'sd50; end
            endcase
            step();
            if (k == 14) chk("b_rv_early", res_valid_b, 0);
        end
        s_valid_bc = 1'b0;
        chk("b_rv", res_valid_b, 1);
        chk("b_i_in", i_in_b, 240);
        chk("b_q_in", q_in_b, 0);
        chk("b_i_out", i_out_b, 0);
        chk("b_q_out", q_out_b, 400);

        // Instance C: full-scale alternating input over 1088 samples
        rst_n_bc = 1'b0;
        step();
        rst_n_bc = 1'b1;
        start_bc = 1'b1;
        step();
        start_bc = 1'b0;
        chk("c_busy", busy_c, 1);
        for (int n = 0; n < 1088; n++) begin
            s_valid_bc = 1'b1;
            s_out_bc   = 12'sd0;
            case (n % 4)
                0:       s_in_bc = -12'sd2048;
                2:       s_in_bc = 12'sd2047;
                default: s_in_bc = 12'sd0;
            endcase
            step();
            if (n == 1086) chk("c_rv_early", res_valid_c, 0);
        end
        s_valid_bc = 1'b0;
        chk("c_rv", res_valid_c, 1);
        chk("c_i_in", i_in_c, -1048320);
        chk("c_q_in", q_in_c, 0);
        chk("c_i_out", i_out_c, 0);
        chk("c_q_out", q_out_c, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
